aec_infix2postfix: RTL and testbench

- Front-end stage of the arithmetic-expression path. Receives the same ASCII character stream the AEC evaluator accepts and checks that the parentheses are legal.
- If the expression is legal, it converts the infix expression into a postfix token stream using a shunting-yard operator stack. A downstream evaluator consumes that stream over a ready/valid handshake.
- Captures a whole expression into an internal buffer, then drains it to tokens. Input never needs to stall.

---
 rtl/aec_pkg.sv | 39 +++
 rtl/aec_op_stack.sv | 41 ++++
 rtl/aec_infix2postfix.sv | 209 ++++++++++++++++++++
 tb/tb_aec_infix2postfix.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// Shared types and constants for the infix-to-postfix front end of the
// arithmetic-expression path.
package aec_pkg;

  typedef enum logic [1:0] {
    TOK_OPERAND  = 2'd0,
    TOK_OPERATOR = 2'd1,
    TOK_END      = 2'd2
  } tok_kind_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CONVERT,
    S_FLUSH,
    S_FINISH
  } state_e;

  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_EQ     = 8'h3D;

  // Stack entries are 3 bits: an operator code, or this marker for '('.
  localparam logic [2:0] STK_LPAREN = 3'd3;

  function automatic logic [1:0] prec(input logic [2:0] entry);
    return (entry == {1'b0, OP_MUL}) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/aec_op_stack.sv
// LIFO of 3-bit operator-stack entries with push/pop and a combinational top.
module aec_op_stack #(
  parameter int STK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] push_data,
  output logic [2:0] top,
  output logic       empty
);

  localparam int AW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int PW = $clog2(STK_DEPTH + 1);

  logic [2:0]    mem [STK_DEPTH];
  logic [PW-1:0] sp;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = AW'(sp);
  assign top_idx = AW'(sp - PW'(1));
  assign top     = mem[top_idx];
  assign empty   = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
    end else if (pop) begin
      sp <= sp - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/aec_infix2postfix.sv
// Captures an ASCII infix expression, checks parenthesis legality and emits a
// postfix token stream. Build option AEC_HEX_DIGIT_EN accepts 'a'-'f' operands.
module aec_infix2postfix
  import aec_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int STK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] ascii_in,
  output logic       tok_valid,
  input  logic       tok_ready,
  output logic [1:0] tok_kind,
  output logic [3:0] tok_data,
  output logic       done,
  output logic       paren_legal,
  output logic       busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int DW = $clog2(MAX_LEN) + 1;

  function automatic logic is_operand(input logic [7:0] c);
`ifdef AEC_HEX_DIGIT_EN
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66);
`else
    return (c >= 8'h30 && c <= 8'h39);
`endif
  endfunction

  function automatic logic [3:0] operand_val(input logic [7:0] c);
    return (c >= 8'h61) ? 4'(c - 8'h57) : 4'(c - 8'h30);
  endfunction

  function automatic logic [2:0] op_code(input logic [7:0] c);
    if (c == CH_STAR)  return {1'b0, OP_MUL};
    if (c == CH_MINUS) return {1'b0, OP_SUB};
    return {1'b0, OP_ADD};
  endfunction

  state_e        state;
  logic [7:0]    char_buf [MAX_LEN];
  logic [AW-1:0] wp, rp;
  logic [DW-1:0] depth;
  logic          legal;

  logic          cap_we, cap_end, nl;
  logic [AW-1:0] cap_idx;
  logic [DW-1:0] nd;
  logic [7:0]    cur;
  logic          out_free, end_pending;
  logic          emit, adv, push, pop, go_flush;
  tok_kind_e     emit_kind;
  logic [3:0]    emit_data;
  logic [2:0]    push_data, stk_top;
  logic          stk_empty;

  aec_op_stack #(.STK_DEPTH(STK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (stk_top),
    .empty     (stk_empty)
  );

  // The first character is judged against a fresh depth/legal pair.
  always_comb begin
    cap_idx = (state == S_IDLE) ? '0 : wp;
    nd      = (state == S_IDLE) ? '0 : depth;
    nl      = (state == S_IDLE) ? 1'b1 : legal;
    if (ascii_in == CH_LPAREN) begin
      nd = nd + DW'(1);
    end else if (ascii_in == CH_RPAREN) begin
      if (nd == '0) nl = 1'b0;
      else          nd = nd - DW'(1);
    end else if (!(is_operand(ascii_in) || ascii_in == CH_PLUS || ascii_in == CH_MINUS ||
                   ascii_in == CH_STAR || ascii_in == CH_EQ)) begin
      nl = 1'b0;
    end
    cap_end = (ascii_in == CH_EQ) || (cap_idx == AW'(MAX_LEN - 1));
    if (ascii_in == CH_EQ && nd != '0) nl = 1'b0;
    if (ascii_in != CH_EQ && cap_idx == AW'(MAX_LEN - 1)) nl = 1'b0;
  end

  assign cap_we      = (state == S_IDLE && ready && !busy) || (state == S_CAPTURE);
  assign cur         = char_buf[rp];
  assign out_free    = !tok_valid || tok_ready;
  assign end_pending = tok_valid && (tok_kind == TOK_END);

  // Shunting-yard step: at most one stack action and one token per cycle.
  always_comb begin
    emit      = 1'b0;
    emit_kind = TOK_OPERAND;
    emit_data = '0;
    adv       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    go_flush  = 1'b0;
    if (state == S_CONVERT && out_free) begin
      if (is_operand(cur)) begin
        emit      = 1'b1;
        emit_data = operand_val(cur);
        adv       = 1'b1;
      end else if (cur == CH_LPAREN) begin
        push      = 1'b1;
        push_data = STK_LPAREN;
        adv       = 1'b1;
      end else if (cur == CH_RPAREN) begin
        pop = 1'b1;
        if (stk_top != STK_LPAREN) begin
          emit      = 1'b1;
          emit_kind = TOK_OPERATOR;
          emit_data = {2'b00, stk_top[1:0]};
        end else begin
          adv = 1'b1;
        end
      end else if (cur == CH_EQ) begin
        go_flush = 1'b1;
      end else if (!stk_empty && stk_top != STK_LPAREN &&
                   prec(stk_top) >= prec(op_code(cur))) begin
        pop       = 1'b1;
        emit      = 1'b1;
        emit_kind = TOK_OPERATOR;
        emit_data = {2'b00, stk_top[1:0]};
      end else begin
        push      = 1'b1;
        push_data = op_code(cur);
        adv       = 1'b1;
      end
    end else if (state == S_FLUSH && out_free && !end_pending) begin
      emit = 1'b1;
      if (!stk_empty) begin
        pop       = 1'b1;
        emit_kind = TOK_OPERATOR;
        emit_data = {2'b00, stk_top[1:0]};
      end else begin
        emit_kind = TOK_END;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we) char_buf[cap_idx] <= ascii_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tok_valid   <= 1'b0;
      tok_kind    <= '0;
      tok_data    <= '0;
      done        <= 1'b0;
      paren_legal <= 1'b0;
      busy        <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      depth       <= '0;
      legal       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (emit) begin
        tok_valid <= 1'b1;
        tok_kind  <= emit_kind;
        tok_data  <= emit_data;
      end else if (tok_ready) begin
        tok_valid <= 1'b0;
      end
      if (adv) rp <= rp + AW'(1);
      case (state)
        S_IDLE: begin
          // busy stays up through the done cycle, which is spent here.
          if (done) busy <= 1'b0;
          if (ready && !busy) begin
            busy  <= 1'b1;
            depth <= nd;
            legal <= nl;
            wp    <= AW'(1);
            rp    <= '0;
            if (cap_end) state <= nl ? S_CONVERT : S_FINISH;
            else         state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          depth <= nd;
          legal <= nl;
          wp    <= wp + AW'(1);
          if (cap_end) begin
            rp    <= '0;
            state <= nl ? S_CONVERT : S_FINISH;
          end
        end
        S_CONVERT: if (go_flush) state <= S_FLUSH;
        S_FLUSH:   if (end_pending && tok_ready) state <= S_FINISH;
        S_FINISH: begin
          done        <= 1'b1;
          paren_legal <= legal;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aec_infix2postfix.sv
// Directed bench for aec_infix2postfix: token order, legality, timing, stalls, reset abort.
module tb_aec_infix2postfix;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] ascii_in;
  logic       tok_valid;
  logic       tok_ready;
  logic [1:0] tok_kind;
  logic [3:0] tok_data;
  logic       done;
  logic       paren_legal;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  aec_infix2postfix dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .ascii_in    (ascii_in),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_kind    (tok_kind),
    .tok_data    (tok_data),
    .done        (done),
    .paren_legal (paren_legal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Tokens rendered as text: digits/'a'-'f' operands, + - * operators, E for END.
  function automatic string tok_str(input logic [1:0] k, input logic [3:0] d);
    if (k == 2'd0) begin
      if (d < 4'd10) return $sformatf("%0d", d);
      return $sformatf("%c", 8'(8'h57 + 8'(d)));
    end
    if (k == 2'd1) begin
      if (d == 4'd0) return "+";
      if (d == 4'd1) return "-";
      if (d == 4'd2) return "*";
      return "?";
    end
    if (k == 2'd2) return "E";
    return "?";
  endfunction

  // Leaves the bench at the negedge right after the '=' capture edge.
  task automatic send_expr(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ready    = (i == 0);
      ascii_in = s[i];
    end
    @(negedge clk);
    ready    = 1'b0;
    ascii_in = 8'h00;
  endtask

  // Cycle numbering: 1 = second negedge after the '=' capture edge.
  task automatic collect(input string prefix, output string got, output int first_at,
                         output int end_at, output int done_at, output logic lg);
    got      = prefix;
    first_at = -1;
    end_at   = -1;
    done_at  = -1;
    lg       = 1'bx;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (tok_valid && first_at < 0) first_at = c;
      if (tok_valid && tok_ready) begin
        got = {got, tok_str(tok_kind, tok_data)};
        if (tok_kind == 2'd2) end_at = c;
      end
      if (done) begin
        done_at = c;
        lg      = paren_legal;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ready = 1'b0; ascii_in = 8'h00; tok_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tok_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tok_valid got=%b exp=0", tok_valid); end
    n_cmp++; if (tok_kind !== 2'd0) begin n_fail++; $display("FAIL reset_tok_kind got=%0d exp=0", tok_kind); end
    n_cmp++; if (tok_data !== 4'd0) begin n_fail++; $display("FAIL reset_tok_data got=%0d exp=0", tok_data); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (paren_legal !== 1'b0) begin n_fail++; $display("FAIL reset_paren_legal got=%b exp=0", paren_legal); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_paren_expr;
    string got; int f, e, d; logic lg;
    send_expr("(1+2)*3=");
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL paren_busy_mid got=%b exp=1", busy); end
    collect("", got, f, e, d, lg);
    n_cmp++; if (got != "12+3*E") begin n_fail++; $display("FAIL paren_tokens got=%s exp=12+3*E", got); end
    n_cmp++; if (lg !== 1'b1) begin n_fail++; $display("FAIL paren_legal got=%b exp=1", lg); end
    n_cmp++; if (e < 0 || d - e < 1 || d - e > 2) begin
      n_fail++; $display("FAIL paren_done_after_end got=end@%0d done@%0d exp=done 1-2 cycles after END", e, d);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL paren_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_precedence;
    string got; int f, e, d; logic lg;
    send_expr("2+3*4-1=");
    collect("", got, f, e, d, lg);
    n_cmp++; if (got != "234*+1-E") begin n_fail++; $display("FAIL prec_tokens got=%s exp=234*+1-E", got); end
    n_cmp++; if (f !== 1) begin n_fail++; $display("FAIL prec_first_latency got=%0d exp=1", f); end
    n_cmp++; if (lg !== 1'b1) begin n_fail++; $display("FAIL prec_legal got=%b exp=1", lg); end
  endtask

  task automatic test_illegal;
    string got; int f, e, d; logic lg;
    send_expr("(1+2))=");
    collect("", got, f, e, d, lg);
    n_cmp++; if (f !== -1) begin n_fail++; $display("FAIL extra_rparen_no_tokens got=first@%0d exp=none", f); end
    n_cmp++; if (d !== 1) begin n_fail++; $display("FAIL extra_rparen_done_lat got=%0d exp=1", d); end
    n_cmp++; if (lg !== 1'b0) begin n_fail++; $display("FAIL extra_rparen_legal got=%b exp=0", lg); end
    send_expr("((3)=");
    collect("", got, f, e, d, lg);
    n_cmp++; if (f !== -1) begin n_fail++; $display("FAIL open_paren_no_tokens got=first@%0d exp=none", f); end
    n_cmp++; if (d !== 1) begin n_fail++; $display("FAIL open_paren_done_lat got=%0d exp=1", d); end
    n_cmp++; if (lg !== 1'b0) begin n_fail++; $display("FAIL open_paren_legal got=%b exp=0", lg); end
  endtask

  task automatic test_stall;
    string got; int f, e, d; logic lg; int seen;
    send_expr("9-8-7=");
    seen = 0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (tok_valid) seen = c;
    end
    tok_ready = 1'b0;
    n_cmp++; if (seen !== 1 || tok_data !== 4'd9) begin
      n_fail++; $display("FAIL stall_first got=cycle %0d data %0d exp=cycle 1 data 9", seen, tok_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (tok_valid !== 1'b1 || tok_kind !== 2'd0 || tok_data !== 4'd9) begin
        n_fail++; $display("FAIL stall_hold_%0d got=v%b k%0d d%0d exp=v1 k0 d9", i, tok_valid, tok_kind, tok_data);
      end
    end
    tok_ready = 1'b1;
    got = tok_valid ? tok_str(tok_kind, tok_data) : "";
    collect(got, got, f, e, d, lg);
    n_cmp++; if (got != "98-7-E") begin n_fail++; $display("FAIL stall_tokens got=%s exp=98-7-E", got); end
    n_cmp++; if (lg !== 1'b1) begin n_fail++; $display("FAIL stall_legal got=%b exp=1", lg); end
  endtask

  task automatic test_reset_abort;
    string got; int f, e, d; logic lg;
    send_expr("1+2*3=");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (tok_valid !== 1'b0) begin n_fail++; $display("FAIL abort_tok_valid got=%b exp=0", tok_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
    send_expr("4=");
    collect("", got, f, e, d, lg);
    n_cmp++; if (got != "4E") begin n_fail++; $display("FAIL abort_next_tokens got=%s exp=4E", got); end
    n_cmp++; if (d < 0) begin n_fail++; $display("FAIL abort_next_done got=timeout exp=done pulse"); end
    n_cmp++; if (lg !== 1'b1) begin n_fail++; $display("FAIL abort_next_legal got=%b exp=1", lg); end
  endtask

  task automatic test_hex;
    string got; int f, e, d; logic lg;
    send_expr("a+1=");
    collect("", got, f, e, d, lg);
`ifdef AEC_HEX_DIGIT_EN
    n_cmp++; if (got != "a1+E") begin n_fail++; $display("FAIL hex_tokens got=%s exp=a1+E", got); end
    n_cmp++; if (lg !== 1'b1) begin n_fail++; $display("FAIL hex_legal got=%b exp=1", lg); end
`else
    n_cmp++; if (got != "") begin n_fail++; $display("FAIL hex_tokens got=%s exp=(none)", got); end
    n_cmp++; if (lg !== 1'b0) begin n_fail++; $display("FAIL hex_legal got=%b exp=0", lg); end
`endif
  endtask

  task automatic test_overflow;
    string s, got; int f, e, d; logic lg;
    s = "";
    for (int i = 0; i < 32; i++) s = {s, "1"};
    send_expr(s);
    collect("", got, f, e, d, lg);
    n_cmp++; if (d !== 1) begin n_fail++; $display("FAIL overflow_done_lat got=%0d exp=1", d); end
    n_cmp++; if (lg !== 1'b0 || f !== -1) begin
      n_fail++; $display("FAIL overflow_legal got=legal %b first@%0d exp=legal 0 no tokens", lg, f);
    end
  endtask

  initial begin
    test_reset();
    test_paren_expr();
    test_precedence();
    test_illegal();
    test_stall();
    test_reset_abort();
    test_hex();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
